gnn_readout: RTL and testbench

GNN_READOUT -- requirements
Module: gnn_readout

---
 rtl/gnn_pkg.sv | 19 +
 rtl/gnn_node_cmp.sv | 25 ++
 rtl/gnn_readout.sv | 163 ++++++++++++++++
 tb/tb_gnn_readout.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gnn_pkg.sv
// Shared constants and the readout FSM state type for the GNN readout slice.
package gnn_pkg;

  localparam int NODES  = 4;
  localparam int IN_W   = 21;
  localparam int POOL_W = IN_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2,
    ST_REARM = 2'd3
  } readout_state_t;

  function automatic logic all_set(input logic [2*NODES-1:0] flags);
    return &flags;
  endfunction

endpackage

// File: rtl/gnn_node_cmp.sv
// Per-node score conditioning (optional ReLU via GNN_READOUT_RELU_EN) and signed class compare.
module gnn_node_cmp #(
  parameter int W = 21
) (
  input  logic signed [W-1:0] score0,
  input  logic signed [W-1:0] score1,
  output logic signed [W-1:0] eff0,
  output logic signed [W-1:0] eff1,
  output logic                gt
);
  import gnn_pkg::*;

  always_comb begin
`ifdef GNN_READOUT_RELU_EN
    eff0 = score0[W-1] ? '0 : score0;
    eff1 = score1[W-1] ? '0 : score1;
`else
    eff0 = score0;
    eff1 = score1;
`endif
    // A tie resolves to class 0.
    gt = (eff1 > eff0);
  end

endmodule

// File: rtl/gnn_readout.sv
// Graph readout: captures four nodes' class scores, classifies each node, sums them into
// graph-level pools over four cycles and hands the result off. Option: GNN_READOUT_RELU_EN.
module gnn_readout #(
  parameter int IN_W   = gnn_pkg::IN_W,
  parameter int POOL_W = IN_W + 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [IN_W-1:0]   out0_node0,
  input  logic signed [IN_W-1:0]   out0_node1,
  input  logic signed [IN_W-1:0]   out0_node2,
  input  logic signed [IN_W-1:0]   out0_node3,
  input  logic signed [IN_W-1:0]   out1_node0,
  input  logic signed [IN_W-1:0]   out1_node1,
  input  logic signed [IN_W-1:0]   out1_node2,
  input  logic signed [IN_W-1:0]   out1_node3,
  input  logic                     out0_ready_node0,
  input  logic                     out0_ready_node1,
  input  logic                     out0_ready_node2,
  input  logic                     out0_ready_node3,
  input  logic                     out1_ready_node0,
  input  logic                     out1_ready_node1,
  input  logic                     out1_ready_node2,
  input  logic                     out1_ready_node3,
  output logic                     class_node0,
  output logic                     class_node1,
  output logic                     class_node2,
  output logic                     class_node3,
  output logic signed [POOL_W-1:0] pool0,
  output logic signed [POOL_W-1:0] pool1,
  output logic                     graph_class,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic                     busy,
  output logic [1:0]               fsm_state
);
  import gnn_pkg::*;

  // Handshake: result_valid rises when the result is complete and holds, with all result
  // outputs stable, until an edge sees result_valid && result_ready; that edge consumes it.
  // The upstream side is level based: a capture needs all eight ready flags high, and a new
  // capture is only allowed after the flags have been seen low at least once.

  localparam int IDX_W = (NODES > 1) ? $clog2(NODES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NODES - 1);

  readout_state_t state;
  logic [IDX_W-1:0] idx;
  logic [NODES-1:0] class_q;
  logic [NODES-1:0] gt;
  logic             all_ready;

  logic signed [IN_W-1:0] in0  [NODES];
  logic signed [IN_W-1:0] in1  [NODES];
  logic signed [IN_W-1:0] cap0 [NODES];
  logic signed [IN_W-1:0] cap1 [NODES];
  logic signed [IN_W-1:0] eff0 [NODES];
  logic signed [IN_W-1:0] eff1 [NODES];

  logic signed [IN_W-1:0]   cur0;
  logic signed [IN_W-1:0]   cur1;
  logic signed [POOL_W-1:0] ext0;
  logic signed [POOL_W-1:0] ext1;
  logic signed [POOL_W-1:0] sum0;
  logic signed [POOL_W-1:0] sum1;

  assign in0[0] = out0_node0;
  assign in0[1] = out0_node1;
  assign in0[2] = out0_node2;
  assign in0[3] = out0_node3;
  assign in1[0] = out1_node0;
  assign in1[1] = out1_node1;
  assign in1[2] = out1_node2;
  assign in1[3] = out1_node3;

  assign all_ready = all_set({out0_ready_node3, out0_ready_node2, out0_ready_node1,
                              out0_ready_node0, out1_ready_node3, out1_ready_node2,
                              out1_ready_node1, out1_ready_node0});

  for (genvar k = 0; k < NODES; k++) begin : g_node
    gnn_node_cmp #(.W(IN_W)) u_cmp (
      .score0 (cap0[k]),
      .score1 (cap1[k]),
      .eff0   (eff0[k]),
      .eff1   (eff1[k]),
      .gt     (gt[k])
    );
  end

  // Running sums for the node selected by idx; used on every ACCUM edge.
  always_comb begin
    cur0 = eff0[idx];
    cur1 = eff1[idx];
    ext0 = {{(POOL_W-IN_W){cur0[IN_W-1]}}, cur0};
    ext1 = {{(POOL_W-IN_W){cur1[IN_W-1]}}, cur1};
    sum0 = pool0 + ext0;
    sum1 = pool1 + ext1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      idx          <= '0;
      class_q      <= '0;
      pool0        <= '0;
      pool1        <= '0;
      graph_class  <= 1'b0;
      result_valid <= 1'b0;
      for (int k = 0; k < NODES; k++) begin
        cap0[k] <= '0;
        cap1[k] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (all_ready) begin
            for (int k = 0; k < NODES; k++) begin
              cap0[k] <= in0[k];
              cap1[k] <= in1[k];
            end
            pool0 <= '0;
            pool1 <= '0;
            idx   <= '0;
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          pool0        <= sum0;
          pool1        <= sum1;
          class_q[idx] <= gt[idx];
          if (idx == LAST_IDX) begin
            graph_class  <= (sum1 > sum0);
            result_valid <= 1'b1;
            state        <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            state        <= ST_REARM;
          end
        end
        ST_REARM: begin
          // Wait for upstream to drop its flags so the same result is not captured twice.
          if (!all_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (state != ST_IDLE);
  assign fsm_state   = state;
  assign class_node0 = class_q[0];
  assign class_node1 = class_q[1];
  assign class_node2 = class_q[2];
  assign class_node3 = class_q[3];

endmodule

// File: tb/tb_gnn_readout.sv
// Self-checking bench for gnn_readout: timeline model with expected-result queue plus literal checks.
module tb_gnn_readout;

  localparam int IN_W   = 21;
  localparam int POOL_W = 23;
  localparam int EXP_W  = 1 + 4 + 2 * POOL_W;

`ifdef GNN_READOUT_RELU_EN
  localparam int E33_P0 = 17;
  localparam int E33_P1 = 11;
  localparam int E35_P0 = 0;
`else
  localparam int E33_P0 = 12;
  localparam int E33_P1 = 9;
  localparam int E35_P0 = -4194304;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic signed [IN_W-1:0]   o0 [4];
  logic signed [IN_W-1:0]   o1 [4];
  logic                     rd0 [4];
  logic                     rd1 [4];
  logic                     result_ready = 1'b0;
  logic                     class_node0, class_node1, class_node2, class_node3;
  logic signed [POOL_W-1:0] pool0, pool1;
  logic                     graph_class, result_valid, busy;
  logic [1:0]               fsm_state;

  int n_cmp  = 0;
  int n_fail = 0;

  gnn_readout #(.IN_W(IN_W), .POOL_W(POOL_W)) dut (
    .clk(clk), .rst(rst),
    .out0_node0(o0[0]), .out0_node1(o0[1]), .out0_node2(o0[2]), .out0_node3(o0[3]),
    .out1_node0(o1[0]), .out1_node1(o1[1]), .out1_node2(o1[2]), .out1_node3(o1[3]),
    .out0_ready_node0(rd0[0]), .out0_ready_node1(rd0[1]),
    .out0_ready_node2(rd0[2]), .out0_ready_node3(rd0[3]),
    .out1_ready_node0(rd1[0]), .out1_ready_node1(rd1[1]),
    .out1_ready_node2(rd1[2]), .out1_ready_node3(rd1[3]),
    .class_node0(class_node0), .class_node1(class_node1),
    .class_node2(class_node2), .class_node3(class_node3),
    .pool0(pool0), .pool1(pool1), .graph_class(graph_class),
    .result_valid(result_valid), .result_ready(result_ready),
    .busy(busy), .fsm_state(fsm_state)
  );

  // ---------------- check helper ----------------
  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [EXP_W-1:0] exp_q[$];
  logic                     m_busy  = 1'b0;
  logic                     m_valid = 1'b0;
  int                       m_cnt   = 0;
  logic                     e_graph = 1'b0;
  logic [3:0]               e_class = '0;
  logic signed [POOL_W-1:0] e_pool0 = '0;
  logic signed [POOL_W-1:0] e_pool1 = '0;

  function automatic logic flags_all();
    logic r;
    r = 1'b1;
    for (int k = 0; k < 4; k++) r = r & rd0[k] & rd1[k];
    return r;
  endfunction

  // Whole-graph result straight from the scores currently presented.
  function automatic logic [EXP_W-1:0] predict();
    int a, b, p0, p1;
    logic [3:0] c;
    p0 = 0; p1 = 0; c = '0;
    for (int k = 0; k < 4; k++) begin
      a = int'(o0[k]);
      b = int'(o1[k]);
`ifdef GNN_READOUT_RELU_EN
      if (a < 0) a = 0;
      if (b < 0) b = 0;
`endif
      p0 += a;
      p1 += b;
      c[k] = (b > a);
    end
    return {(p1 > p0), c, POOL_W'(p1), POOL_W'(p0)};
  endfunction

  // Timeline: capture, result visible four edges later, held until consumed, then the
  // block stays busy until upstream flags are seen low.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_valid = 1'b0; m_cnt = 0;
      e_graph = 1'b0; e_class = '0; e_pool0 = '0; e_pool1 = '0;
      exp_q.delete();
    end else if (!m_busy) begin
      if (flags_all()) begin
        exp_q.push_back(predict());
        m_busy = 1'b1;
        m_cnt  = 4;
      end
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_valid = 1'b1;
        if (exp_q.size() > 0) {e_graph, e_class, e_pool1, e_pool0} = exp_q.pop_front();
      end
    end else if (m_valid) begin
      if (result_ready) m_valid = 1'b0;
    end else if (!flags_all()) begin
      m_busy = 1'b0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    check("busy", busy, m_busy);
    check("result_valid", result_valid, m_valid);
    if (m_cnt == 0) begin
      check("pool0", longint'(pool0), longint'(e_pool0));
      check("pool1", longint'(pool1), longint'(e_pool1));
      check("class", {class_node3, class_node2, class_node1, class_node0}, e_class);
      check("graph_class", graph_class, e_graph);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_scores(input int a0, a1, a2, a3, input int b0, b1, b2, b3);
    o0[0] = IN_W'(a0); o0[1] = IN_W'(a1); o0[2] = IN_W'(a2); o0[3] = IN_W'(a3);
    o1[0] = IN_W'(b0); o1[1] = IN_W'(b1); o1[2] = IN_W'(b2); o1[3] = IN_W'(b3);
  endtask

  task automatic set_ready(input logic v);
    for (int k = 0; k < 4; k++) begin
      rd0[k] = v;
      rd1[k] = v;
    end
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 50 && !result_valid; i++) tick(1);
    if (!result_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: result_valid timeout, got 0, want 1", name);
    end
  endtask

  task automatic handshake();
    result_ready = 1'b1;
    tick(1);
    result_ready = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    set_scores(0, 0, 0, 0, 0, 0, 0, 0);
    set_ready(1'b0);
    tick(3);
    check("reset_busy", busy, 0);
    check("reset_pool0", longint'(pool0), 0);
    #3 rst = 1'b0;
    tick(2);

    // Mixed scores with a tie on node 2; flags drop during ACCUM and are ignored.
    set_scores(-5, 10, 7, 0, 3, -2, 7, 1);
    set_ready(1'b1);
    tick(1);
    check("cap_busy", busy, 1);
    set_ready(1'b0);
    tick(3);
    check("lat3_valid", result_valid, 0);
    tick(1);
    check("lat4_valid", result_valid, 1);
    check("mix_class", {class_node3, class_node2, class_node1, class_node0}, 4'b1001);
    check("mix_pool0", longint'(pool0), E33_P0);
    check("mix_pool1", longint'(pool1), E33_P1);
    check("mix_graph", graph_class, 0);
    tick(10);
    check("bp_busy", busy, 1);
    check("bp_valid", result_valid, 1);
    check("bp_pool0", longint'(pool0), E33_P0);
    handshake();
    check("rearm_valid", result_valid, 0);
    check("rearm_busy", busy, 1);
    tick(1);
    check("idle_busy", busy, 0);
    check("retain_pool1", longint'(pool1), E33_P1);
    tick(2);

    // Extremes with flags held high; result_ready pulsed during ACCUM is ignored.
    set_scores(-1048576, -1048576, -1048576, -1048576, 1048575, 1048575, 1048575, 1048575);
    set_ready(1'b1);
    tick(1);
    result_ready = 1'b1;
    tick(2);
    result_ready = 1'b0;
    wait_valid("ext");
    check("ext_pool0", longint'(pool0), E35_P0);
    check("ext_pool1", longint'(pool1), 4194300);
    check("ext_class", {class_node3, class_node2, class_node1, class_node0}, 4'b1111);
    check("ext_graph", graph_class, 1);
    handshake();
    tick(5);
    check("hold_no_recap_busy", busy, 1);
    check("hold_no_recap_valid", result_valid, 0);
    set_ready(1'b0);
    tick(1);
    check("drop_idle", busy, 0);
    set_scores(100, -50, -1, 0, 100, -60, -2, 0);
    set_ready(1'b1);
    tick(1);
    check("recap_busy", busy, 1);
    set_ready(1'b0);
    wait_valid("tie");
    check("tie_class", {class_node3, class_node2, class_node1, class_node0}, 4'b0000);
    handshake();
    tick(2);

    // Reset two edges into ACCUM, released with flags already high.
    set_scores(1, 2, 3, 4, 4, 3, 2, 1);
    set_ready(1'b1);
    tick(3);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pool0", longint'(pool0), 0);
    check("mid_rst_class", {class_node3, class_node2, class_node1, class_node0}, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    tick(1);
    check("post_rst_capture", busy, 1);
    set_ready(1'b0);
    wait_valid("post_rst");
    check("post_rst_pool0", longint'(pool0), 10);
    handshake();
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
